// File: rtl/btb_update_ctrl.sv
// BTB update controller: buffers resolved branches, drives the global counter and
// fetch redirect, and serialises BTB writes (record drain or full invalidate sweep).
module btb_update_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        res_valid,
  input  logic [15:0] res_pc,
  input  logic [15:0] res_target,
  input  logic        res_taken,
  input  logic        res_mispredict,
  output logic        res_ready,
  input  logic        inv_req,
  output logic        inv_busy,
  output logic        btb_we,
  output logic [7:0]  btb_index,
  output logic [7:0]  btb_tag,
  output logic [15:0] btb_target,
  output logic        ctr_update,
  output logic        ctr_taken,
  output logic        redirect,
  output logic [15:0] redirect_pc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, SWEEP} state_t;

  state_t             state, state_nxt;
  logic [7:0]         sweep_cnt;
  logic               inv_pend, inv_pend_nxt;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               push, pop;

  logic signed [15:0] mem_pc     [FIFO_DEPTH];
  logic signed [15:0] mem_target [FIFO_DEPTH];
  logic               mem_taken  [FIFO_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [15:0] fallthrough(input logic [15:0] pc);
    return pc + 16'd1;
  endfunction

  // Full is derived from the registered count only, so a same-cycle pop cannot raise ready.
  assign res_ready = (count != CNT_W'(FIFO_DEPTH));
  assign push      = res_valid && res_ready;

  always_comb begin
    state_nxt    = state;
    inv_pend_nxt = inv_pend;
    pop          = 1'b0;
    btb_we       = 1'b0;
    btb_index    = 8'h00;
    btb_tag      = 8'h00;
    btb_target   = 16'h0000;
    inv_busy     = 1'b0;
    case (state)
      IDLE: begin
        if (inv_req || inv_pend) begin
          state_nxt    = SWEEP;
          inv_pend_nxt = 1'b0;
        end else if (count != '0) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        pop        = 1'b1;
        btb_we     = 1'b1;
        btb_index  = mem_pc[rd_ptr][7:0];
        btb_tag    = mem_pc[rd_ptr][15:8];
        btb_target = mem_taken[rd_ptr] ? mem_target[rd_ptr] : 16'hFFFF;
        if (inv_req) inv_pend_nxt = 1'b1;
        if (count == CNT_W'(1) && !push) state_nxt = IDLE;
      end
      SWEEP: begin
        btb_we     = 1'b1;
        btb_index  = sweep_cnt;
        btb_tag    = 8'h00;
        btb_target = 16'hFFFF;
        inv_busy   = 1'b1;
        if (sweep_cnt == 8'hFF) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0 -> p1: control state, FIFO bookkeeping, counter/redirect strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sweep_cnt   <= 8'h00;
      inv_pend    <= 1'b0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ctr_update  <= 1'b0;
      ctr_taken   <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= 16'h0000;
    end else begin
      state      <= state_nxt;
      inv_pend   <= inv_pend_nxt;
      sweep_cnt  <= (state == SWEEP) ? sweep_cnt + 8'd1 : 8'h00;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      ctr_update <= push;
      ctr_taken  <= push && res_taken;
      redirect   <= push && res_mispredict;
      if (push && res_mispredict)
        redirect_pc <= res_taken ? res_target : fallthrough(res_pc);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]     <= res_pc;
      mem_target[wr_ptr] <= res_target;
      mem_taken[wr_ptr]  <= res_taken;
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Self-checking bench for btb_update_ctrl: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_btb_update_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        res_valid, res_taken, res_mispredict, inv_req;
  logic [15:0] res_pc, res_target;
  logic        res_ready, inv_busy, btb_we, ctr_update, ctr_taken, redirect;
  logic [7:0]  btb_index, btb_tag;
  logic [15:0] btb_target, redirect_pc;

  btb_update_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .res_valid(res_valid), .res_pc(res_pc),
    .res_target(res_target), .res_taken(res_taken), .res_mispredict(res_mispredict),
    .res_ready(res_ready), .inv_req(inv_req), .inv_busy(inv_busy), .btb_we(btb_we),
    .btb_index(btb_index), .btb_tag(btb_tag), .btb_target(btb_target),
    .ctr_update(ctr_update), .ctr_taken(ctr_taken), .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending records and the current activity of the BTB port.
  typedef struct packed { logic [15:0] pc; logic [15:0] target; logic taken; } rec_t;
  localparam int M_IDLE = 0, M_DRAIN = 1, M_SWEEP = 2;
  rec_t        mq[$];
  int          m_mode, m_sidx;
  bit          m_pend, m_cu, m_ct, m_rd;
  logic [15:0] m_rpc;

  task automatic model_reset();
    mq.delete();
    m_mode = M_IDLE; m_sidx = 0; m_pend = 0;
    m_cu = 0; m_ct = 0; m_rd = 0; m_rpc = 16'h0000;
  endtask

  task automatic model_step();
    int n;
    bit accept;
    n = mq.size();
    accept = res_valid && (n < DEPTH);
    m_cu = accept;
    m_ct = res_taken;
    m_rd = accept && res_mispredict;
    if (m_rd) m_rpc = res_taken ? res_target : res_pc + 16'd1;
    case (m_mode)
      M_IDLE: begin
        if (inv_req || m_pend) begin m_mode = M_SWEEP; m_pend = 0; m_sidx = 0; end
        else if (n > 0) m_mode = M_DRAIN;
      end
      M_DRAIN: begin
        if (inv_req) m_pend = 1;
        void'(mq.pop_front());
        if (n == 1 && !accept) m_mode = M_IDLE;
      end
      default: begin
        if (m_sidx == 255) m_mode = M_IDLE;
        else m_sidx++;
      end
    endcase
    if (accept) mq.push_back('{pc: res_pc, target: res_target, taken: res_taken});
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_btb_we", btb_we, 0);
      chk("rst_ctr_update", ctr_update, 0);
      chk("rst_redirect", redirect, 0);
      chk("rst_inv_busy", inv_busy, 0);
      chk("rst_redirect_pc", redirect_pc, 0);
    end else begin
      chk("res_ready", res_ready, mq.size() < DEPTH);
      chk("inv_busy", inv_busy, m_mode == M_SWEEP);
      chk("btb_we", btb_we, m_mode != M_IDLE);
      chk("ctr_update", ctr_update, m_cu);
      chk("redirect", redirect, m_rd);
      if (m_cu) chk("ctr_taken", ctr_taken, m_ct);
      if (m_rd) chk("redirect_pc", redirect_pc, m_rpc);
      if (m_mode == M_SWEEP) begin
        chk("sweep_index", btb_index, m_sidx);
        chk("sweep_tag", btb_tag, 0);
        chk("sweep_target", btb_target, 16'hFFFF);
      end else if (m_mode == M_DRAIN && mq.size() > 0) begin
        chk("drain_index", btb_index, mq[0].pc[7:0]);
        chk("drain_tag", btb_tag, mq[0].pc[15:8]);
        chk("drain_target", btb_target, mq[0].taken ? mq[0].target : 16'hFFFF);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_rec(input logic [15:0] pc, input logic [15:0] tgt,
                           input logic tk, input logic mp);
    res_valid = 1'b1; res_pc = pc; res_target = tgt; res_taken = tk; res_mispredict = mp;
  endtask

  task automatic idle_in();
    res_valid = 1'b0; res_pc = 16'h0; res_target = 16'h0;
    res_taken = 1'b0; res_mispredict = 1'b0; inv_req = 1'b0;
  endtask

  // Waits for the sweep to end; an overrun counts as a failure.
  task automatic wait_sweep_done(input string nm);
    int k;
    k = 0;
    while (inv_busy && k < 400) begin tick(); k++; end
    chk({nm, "_sweep_done"}, inv_busy, 0);
  endtask

  initial begin
    int busy_cycles, acc;
    logic [7:0] seen[$];
    reset = 1'b1;
    idle_in();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("ready_after_reset", res_ready, 1);
    chk("we_after_reset", btb_we, 0);

    // Taken mispredict: redirect to target, then BTB write of the record
    drive_rec(16'h1234, 16'h1240, 1'b1, 1'b1);
    tick();
    idle_in();
    chk("r38_ctr_update", ctr_update, 1);
    chk("r38_ctr_taken", ctr_taken, 1);
    chk("r38_redirect", redirect, 1);
    chk("r38_redirect_pc", redirect_pc, 16'h1240);
    tick();
    chk("r38_btb_we", btb_we, 1);
    chk("r38_index", btb_index, 8'h34);
    chk("r38_tag", btb_tag, 8'h12);
    chk("r38_target", btb_target, 16'h1240);
    tick();
    chk("r38_redirect_once", redirect, 0);

    // Not-taken mispredict at PC wrap boundary
    drive_rec(16'hFFFF, 16'h0100, 1'b0, 1'b1);
    tick();
    idle_in();
    chk("r39_redirect_pc", redirect_pc, 16'h0000);
    chk("r39_ctr_taken", ctr_taken, 0);
    tick();
    chk("r39_index", btb_index, 8'hFF);
    chk("r39_target", btb_target, 16'hFFFF);
    repeat (3) tick();

    // Invalidate sweep with an empty FIFO
    inv_req = 1'b1;
    tick();
    inv_req = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      if (inv_busy) busy_cycles++;
      tick();
    end
    chk("r40_busy_cycles", busy_cycles, 256);

    // Six back-to-back records during a sweep: only four fit
    inv_req = 1'b1;
    tick();
    inv_req = 1'b0;
    repeat (5) tick();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive_rec(16'hA000 + 16'(i), 16'hB000 + 16'(i), 1'b1, 1'b0);
      if (res_ready) acc++;
      tick();
    end
    idle_in();
    chk("r41_accepted", acc, 4);
    chk("r41_ready_full", res_ready, 0);
    wait_sweep_done("r41");
    for (int i = 0; i < 12; i++) begin
      if (btb_we) seen.push_back(btb_index);
      tick();
    end
    chk("r41_drain_writes", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) chk("r41_order", seen[i], i);

    // inv_req together with a nonempty FIFO in IDLE: sweep goes first
    drive_rec(16'h5566, 16'h5570, 1'b1, 1'b0);
    tick();
    idle_in();
    inv_req = 1'b1;
    tick();
    inv_req = 1'b0;
    chk("r42_sweep_first", inv_busy, 1);
    chk("r42_sweep_index0", btb_index, 8'h00);
    wait_sweep_done("r42");
    seen.delete();
    for (int i = 0; i < 6; i++) begin
      if (btb_we) seen.push_back(btb_index);
      tick();
    end
    chk("r42_drain_after", seen.size(), 1);
    if (seen.size() > 0) chk("r42_drain_index", seen[0], 8'h66);

    // inv_req seen during DRAIN is remembered and serviced afterwards
    for (int i = 0; i < 3; i++) begin
      drive_rec(16'h0C00 + 16'(i), 16'h0D00, 1'b0, 1'b0);
      tick();
    end
    idle_in();
    inv_req = 1'b1;
    tick();
    inv_req = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 10 && !inv_busy; i++) tick();
    chk("latched_inv_sweep", inv_busy, 1);
    wait_sweep_done("latched");
    repeat (3) tick();

    // Reset in the middle of a sweep with records queued
    inv_req = 1'b1;
    tick();
    inv_req = 1'b0;
    drive_rec(16'h7777, 16'h7780, 1'b1, 1'b1);
    tick();
    idle_in();
    repeat (99) tick();
    chk("r43_at_index100", btb_index, 8'd100);
    #2 reset = 1'b1;
    #1;
    chk("r43_async_we", btb_we, 0);
    chk("r43_async_busy", inv_busy, 0);
    chk("r43_async_ctr", ctr_update, 0);
    chk("r43_async_redirect_pc", redirect_pc, 0);
    tick();
    tick();
    reset = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (btb_we) busy_cycles++;
    end
    chk("r43_no_writes_after", busy_cycles, 0);
    chk("r43_ready_after", res_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
